fifomem_wr_arbiter_ctrl: RTL and testbench

//  Single-clock controller for custom_fifomem. Shares the memory write port among NUM_REQ

---
 rtl/fifomem_ctrl_pkg.sv | 38 +++
 rtl/fifomem_wr_arbiter_ctrl_rr_arbiter.sv | 37 +++
 rtl/fifomem_wr_arbiter_ctrl.sv | 119 +++++++++++
 tb/tb_fifomem_wr_arbiter_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fifomem_ctrl_pkg.sv
// Shared types and round-robin helpers for the custom_fifomem write-arbiter controller.
// Requester vectors are carried at the maximum supported width (16) and narrowed by the user.
package fifomem_ctrl_pkg;

    localparam int RR_MAX   = 16;
    localparam int RR_PTR_W = 4;

    typedef logic [RR_MAX-1:0]   rr_vec_t;
    typedef logic [RR_PTR_W-1:0] rr_ptr_t;

    // One-hot winner: first set request at or after rr_ptr, searching circularly over n entries.
    function automatic rr_vec_t rr_pick(input rr_vec_t req, input rr_ptr_t rr_ptr,
                                        input int unsigned n);
        rr_vec_t     gnt;
        logic        found;
        int unsigned idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            idx = (32'(rr_ptr) + i) % n;
            if (i < n && !found && req[idx[RR_PTR_W-1:0]]) begin
                gnt[idx[RR_PTR_W-1:0]] = 1'b1;
                found                  = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic rr_ptr_t rr_next(input rr_vec_t gnt, input int unsigned n);
        int unsigned nxt;
        nxt = 0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            if (gnt[i]) nxt = (i + 1) % n;
        end
        return nxt[RR_PTR_W-1:0];
    endfunction

endpackage

// File: rtl/fifomem_wr_arbiter_ctrl_rr_arbiter.sv
// Round-robin arbiter for the shared memory write port; owns the rotating priority pointer.
// The grant is purely combinational from req, en and rr_ptr.
module rr_arbiter
    import fifomem_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int unsigned N = NUM_REQ;

    rr_ptr_t rr_ptr;
    rr_vec_t req_ext;
    rr_vec_t gnt_ext;

    always_comb begin
        req_ext = '0;
        if (en) req_ext[NUM_REQ-1:0] = req;
        gnt_ext = rr_pick(req_ext, rr_ptr, N);
    end

    assign gnt = gnt_ext[NUM_REQ-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (|gnt_ext) begin
            rr_ptr <= rr_next(gnt_ext, N);
        end
    end

endmodule

// File: rtl/fifomem_wr_arbiter_ctrl.sv
// Single-clock controller for custom_fifomem: arbitrates producers onto the write port,
// tracks pointers/occupancy and flags the memory's registered read data one cycle after a pop.
module fifomem_wr_arbiter_ctrl
    import fifomem_ctrl_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4,
    parameter int NUM_REQ  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ*DATASIZE-1:0]  wdata_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    input  logic                         pop_i,
    output logic                         pop_ack_o,
    output logic                         rvalid_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [ADDRSIZE:0]            count_o,
    output logic                         mem_wen_o,
    output logic [ADDRSIZE-1:0]          mem_wr_addr_o,
    output logic [DATASIZE-1:0]          mem_din_o,
    output logic                         mem_ren_o,
    output logic [ADDRSIZE-1:0]          mem_rd_addr_o,
    output logic                         mem_full_o,
    output logic                         mem_empty_o
);

    localparam int DEPTH = 2 ** ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_CNT = (ADDRSIZE + 1)'(DEPTH);
    localparam logic [ADDRSIZE:0] ONE       = (ADDRSIZE + 1)'(1);

    // Extra MSB is the wrap bit that separates full from empty.
    typedef logic [ADDRSIZE:0] ptr_t;

    ptr_t                wptr;
    ptr_t                rptr;
    ptr_t                wptr_nxt;
    ptr_t                rptr_nxt;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                vld_p1;
    logic [ADDRSIZE:0]   count;
    logic [NUM_REQ-1:0]  gnt;
    logic [DATASIZE-1:0] din;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk (clk_i),
        .rst (rst_i),
        .req (req_i),
        .en  (~full),
        .gnt (gnt)
    );

    assign push = |gnt;
    assign pop  = pop_i & ~empty;

    always_comb begin
        din = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) din = din | wdata_i[k*DATASIZE +: DATASIZE];
        end
    end

    always_comb begin
        wptr_nxt = push ? wptr + ONE : wptr;
        rptr_nxt = pop  ? rptr + ONE : rptr;
    end

    // p0 -> p1: pointers, flags and occupancy; pop registered as the read-valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            wptr   <= wptr_nxt;
            rptr   <= rptr_nxt;
            empty  <= (wptr_nxt == rptr_nxt);
            full   <= (wptr_nxt[ADDRSIZE] != rptr_nxt[ADDRSIZE]) &&
                      (wptr_nxt[ADDRSIZE-1:0] == rptr_nxt[ADDRSIZE-1:0]);
            vld_p1 <= pop;
            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    assign gnt_o         = gnt;
    assign pop_ack_o     = pop;
    assign rvalid_o      = vld_p1;
    assign full_o        = full;
    assign empty_o       = empty;
    assign count_o       = count;
    assign mem_wen_o     = push;
    assign mem_wr_addr_o = wptr[ADDRSIZE-1:0];
    assign mem_din_o     = din;
    assign mem_ren_o     = pop;
    assign mem_rd_addr_o = rptr[ADDRSIZE-1:0];
    assign mem_full_o    = full;
    assign mem_empty_o   = empty;

    a_gnt_onehot:  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop && empty));
    a_count_max:   assert property (@(posedge clk_i) disable iff (rst_i) count <= DEPTH_CNT);
    a_count_ptr:   assert property (@(posedge clk_i) disable iff (rst_i) count == ptr_t'(wptr - rptr));

endmodule

// File: tb/tb_fifomem_wr_arbiter_ctrl.sv
// Randomised bench for fifomem_wr_arbiter_ctrl with a queue-based FIFO model and a
// read-data scoreboard fed from a behavioural copy of custom_fifomem.
module tb_fifomem_wr_arbiter_ctrl;

    localparam int DS    = 8;
    localparam int AS    = 4;
    localparam int NR    = 4;
    localparam int DEPTH = 2 ** AS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*DS-1:0]  wdata = '0;
    logic [NR-1:0]     gnt;
    logic              pop = 1'b0;
    logic              pop_ack;
    logic              rvalid;
    logic              full;
    logic              empty;
    logic [AS:0]       count;
    logic              mem_wen;
    logic [AS-1:0]     wr_addr;
    logic [DS-1:0]     din;
    logic              mem_ren;
    logic [AS-1:0]     rd_addr;
    logic              mem_full;
    logic              mem_empty;

    always #5 clk = ~clk;

    fifomem_wr_arbiter_ctrl #(
        .DATASIZE (DS),
        .ADDRSIZE (AS),
        .NUM_REQ  (NR)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .wdata_i       (wdata),
        .gnt_o         (gnt),
        .pop_i         (pop),
        .pop_ack_o     (pop_ack),
        .rvalid_o      (rvalid),
        .full_o        (full),
        .empty_o       (empty),
        .count_o       (count),
        .mem_wen_o     (mem_wen),
        .mem_wr_addr_o (wr_addr),
        .mem_din_o     (din),
        .mem_ren_o     (mem_ren),
        .mem_rd_addr_o (rd_addr),
        .mem_full_o    (mem_full),
        .mem_empty_o   (mem_empty)
    );

    // Behavioural custom_fifomem: write on wen, registered dout on ren.
    logic [DS-1:0] mem [DEPTH];
    logic [DS-1:0] dout;
    always @(posedge clk) begin
        if (mem_wen) mem[wr_addr] <= din;
        if (mem_ren) dout <= mem[rd_addr];
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO contents as a queue, pushes/pops counted since reset.
    logic [DS-1:0] model_q[$];
    logic [DS-1:0] exp_q[$];
    int            rr = 0;
    int            wcnt = 0;
    int            rcnt = 0;
    bit            rvalid_exp = 1'b0;
    bit            preq [NR];
    logic [DS-1:0] pdata [NR];

    function automatic int pick();
        if (model_q.size() >= DEPTH) return -1;
        for (int k = 0; k < NR; k++) begin
            if (preq[(rr + k) % NR]) return (rr + k) % NR;
        end
        return -1;
    endfunction

    task automatic cycle(input int req_pct, input logic [NR-1:0] mask, input int pop_pct,
                         input bit do_rst);
        int win;
        bit exp_pop;
        @(negedge clk);
        for (int k = 0; k < NR; k++) begin
            if (!preq[k] && mask[k] && $urandom_range(99) < req_pct) begin
                preq[k]  = 1'b1;
                pdata[k] = DS'($urandom);
            end
            req[k]             = preq[k];
            wdata[k*DS +: DS]  = pdata[k];
        end
        pop = ($urandom_range(99) < pop_pct);
        rst = do_rst;
        #1;
        win     = pick();
        exp_pop = pop && (model_q.size() > 0);
        if (!do_rst) begin
            check("gnt", gnt, (win < 0) ? 0 : (1 << win));
            check("mem_wen", mem_wen, win >= 0);
            if (win >= 0) begin
                check("wr_addr", wr_addr, wcnt % DEPTH);
                check("din", din, pdata[win]);
            end
            check("pop_ack", pop_ack, exp_pop);
            check("mem_ren", mem_ren, exp_pop);
            if (exp_pop) check("rd_addr", rd_addr, rcnt % DEPTH);
            check("count", count, model_q.size());
            check("empty", empty, model_q.size() == 0);
            check("full", full, model_q.size() == DEPTH);
            check("mem_empty", mem_empty, model_q.size() == 0);
            check("mem_full", mem_full, model_q.size() == DEPTH);
            check("rvalid", rvalid, rvalid_exp);
        end
        @(posedge clk);
        if (do_rst) begin
            model_q.delete();
            exp_q.delete();
            rr         = 0;
            wcnt       = 0;
            rcnt       = 0;
            rvalid_exp = 1'b0;
            for (int k = 0; k < NR; k++) preq[k] = 1'b0;
        end else begin
            if (exp_pop) begin
                exp_q.push_back(model_q.pop_front());
                rcnt++;
            end
            if (win >= 0) begin
                model_q.push_back(pdata[win]);
                wcnt++;
                rr         = (win + 1) % NR;
                preq[win]  = 1'b0;
            end
            rvalid_exp = exp_pop;
        end
    endtask

    // Read-data monitor: every rvalid must present the next expected word.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rvalid) begin
                if (exp_q.size() == 0) check("rdata_pending", exp_q.size(), 1);
                else check("rdata", dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int k = 0; k < NR; k++) begin
            preq[k]  = 1'b0;
            pdata[k] = '0;
        end
        repeat (2)   cycle(0,   4'h0,   0,   1'b1);
        repeat (10)  cycle(0,   4'h0,   0,   1'b0);
        repeat (20)  cycle(100, 4'hF,   0,   1'b0);
        repeat (6)   cycle(100, 4'hF,   100, 1'b0);
        repeat (24)  cycle(0,   4'h0,   100, 1'b0);
        repeat (3)   cycle(100, 4'hF,   0,   1'b0);
        repeat (40)  cycle(100, 4'hF,   100, 1'b0);
        repeat (300) cycle(50,  4'hF,   45,  1'b0);
        repeat (30)  cycle(0,   4'h0,   100, 1'b0);
        repeat (7)   cycle(100, 4'hF,   0,   1'b0);
        cycle(0, 4'h0, 0, 1'b1);
        repeat (4)   cycle(100, 4'b1010, 0,  1'b0);
        repeat (3)   cycle(0,   4'h0,   100, 1'b0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
